moon_hit_ctrl: RTL and testbench

Collision and life manager sitting directly downstream of the moon enemy. Once per video frame it compares the moon's centre coordinates against the player's centre coordinates with a circular hit test. On a hit it decrements the player's lives and runs an invulnerability window with sprite blinking. It drives the game-over condition consumed by the top-level pixel mux and score/HUD logic.

---
 rtl/stg_pkg.sv | 25 ++
 rtl/circle_hit_pipe.sv | 77 +++++++
 rtl/moon_hit_ctrl.sv | 149 ++++++++++++++
 tb/tb_moon_hit_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// Shared definitions for the stage/playfield logic: playfield geometry,
// coordinate width, the hit-manager state encoding and a small helper used by
// the distance comparators.
package stg_pkg;

  localparam int COORD_W = 10;
  localparam int PLAY_W  = 384;
  localparam int PLAY_H  = 448;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAY      = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } hit_state_t;

  // Magnitude of a two's-complement coordinate difference. Differences of
  // two in-range coordinates always fit in COORD_W bits of magnitude.
  function automatic logic [COORD_W-1:0] abs_mag(input logic [COORD_W:0] d);
    logic [COORD_W:0] n;
    n = d[COORD_W] ? (~d + (COORD_W+1)'(1)) : d;
    return n[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/circle_hit_pipe.sv
// Three-stage circular hit test between two points.
//   clk, reset         : clock, async active-high reset (flushes the pipe)
//   sample             : one-cycle pulse; coordinates are captured this cycle
//   ax, ay, bx, by     : the two centres
//   coll_valid         : one-cycle pulse, three edges after the sample edge
//   coll               : distance^2 < RADIUS^2 for that sample (tangency = miss)
// A new sample while earlier stages are busy discards the older evaluation.
module circle_hit_pipe
  import stg_pkg::*;
#(
  parameter int RADIUS = 52
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               coll_valid,
  output logic               coll
);

  localparam int SUM_W = 2*COORD_W + 1;
  localparam int SQ_W  = 2*COORD_W;
  localparam logic [SUM_W-1:0] R2 = SUM_W'(RADIUS * RADIUS);

  logic [COORD_W:0]   dx_d, dx_q, dy_d, dy_q;
  logic               s1_vld_d, s1_vld_q;
  logic [SUM_W-1:0]   sum_d, sum_q;
  logic               s2_vld_d, s2_vld_q;
  logic               coll_d, coll_q;
  logic               coll_vld_d, coll_vld_q;
  logic [COORD_W-1:0] mag_x, mag_y;
  logic [SQ_W-1:0]    sq_x, sq_y;

  always_comb begin
    dx_d     = {1'b0, ax} - {1'b0, bx};
    dy_d     = {1'b0, ay} - {1'b0, by};
    s1_vld_d = sample;

    mag_x    = abs_mag(dx_q);
    mag_y    = abs_mag(dy_q);
    sq_x     = SQ_W'(mag_x) * SQ_W'(mag_x);
    sq_y     = SQ_W'(mag_y) * SQ_W'(mag_y);
    sum_d    = {1'b0, sq_x} + {1'b0, sq_y};
    // A fresh sample supersedes whatever is still in flight.
    s2_vld_d = s1_vld_q & ~sample;

    coll_d     = (sum_q < R2);
    coll_vld_d = s2_vld_q & ~sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dx_q       <= '0;
      dy_q       <= '0;
      s1_vld_q   <= 1'b0;
      sum_q      <= '0;
      s2_vld_q   <= 1'b0;
      coll_q     <= 1'b0;
      coll_vld_q <= 1'b0;
    end else begin
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      s1_vld_q   <= s1_vld_d;
      sum_q      <= sum_d;
      s2_vld_q   <= s2_vld_d;
      coll_q     <= coll_d;
      coll_vld_q <= coll_vld_d;
    end
  end

  assign coll_valid = coll_vld_q;
  assign coll       = coll_q;

endmodule

// File: rtl/moon_hit_ctrl.sv
// Moon/player collision and life manager.
//   clk, reset          : clock, async active-high reset
//   frame_tick          : one pulse per frame; samples coordinates, counts frames
//   start               : start-button pulse (leaves IDLE / GAME_OVER)
//   player_x/y, moon_x/y: centres in playfield coordinates
//   hit                 : one-cycle pulse when a hit is registered
//   lives               : remaining lives
//   invuln, game_over   : state decodes
//   player_visible      : player sprite enable (blinks while invulnerable)
//   state               : current state
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, collisions ignored
// PLAY      | collisions from the hit pipe cost a life
// INVULN    | post-hit grace period, sprite blinks, collisions ignored
// GAME_OVER | no lives left, sprite hidden, start restarts the game
module moon_hit_ctrl
  import stg_pkg::*;
#(
  parameter int MOON_R        = 48,
  parameter int PLAYER_R      = 4,
  parameter int INIT_LIVES    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_SHIFT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] moon_x,
  input  logic [COORD_W-1:0] moon_y,
  output logic               hit,
  output logic [2:0]         lives,
  output logic               invuln,
  output logic               player_visible,
  output logic               game_over,
  output logic [1:0]         state
);

  localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
  localparam int BLINK_W = BLINK_SHIFT + 1;

  hit_state_t         state_d, state_q;
  logic [2:0]         lives_d, lives_q;
  logic [INV_W-1:0]   inv_cnt_d, inv_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic               hit_d, hit_q;
  logic               vis_d, vis_q;
  logic               coll_valid, coll;

  circle_hit_pipe #(
    .RADIUS(MOON_R + PLAYER_R)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .sample    (frame_tick),
    .ax        (player_x),
    .ay        (player_y),
    .bx        (moon_x),
    .by        (moon_y),
    .coll_valid(coll_valid),
    .coll      (coll)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    blink_cnt_d = blink_cnt_q;
    hit_d       = 1'b0;
    vis_d       = vis_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PLAY;
          lives_d = 3'(INIT_LIVES);
          vis_d   = 1'b1;
        end
      end
      ST_PLAY: begin
        // start is deliberately not looked at here
        if (coll_valid && coll) begin
          hit_d = 1'b1;
          if (lives_q == 3'd1) begin
            lives_d = 3'd0;
            state_d = ST_GAME_OVER;
            vis_d   = 1'b0;
          end else begin
            lives_d     = lives_q - 3'd1;
            inv_cnt_d   = INV_W'(INVULN_FRAMES);
            blink_cnt_d = '0;
            state_d     = ST_INVULN;
            vis_d       = 1'b1;
          end
        end
      end
      ST_INVULN: begin
        if (frame_tick) begin
          inv_cnt_d   = inv_cnt_q - INV_W'(1);
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
          vis_d       = ~blink_cnt_d[BLINK_SHIFT];
          if (inv_cnt_q <= INV_W'(1)) begin
            state_d = ST_PLAY;
            vis_d   = 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        vis_d = 1'b0;
        if (start) begin
          state_d = ST_PLAY;
          lives_d = 3'(INIT_LIVES);
          vis_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lives_q     <= 3'(INIT_LIVES);
      inv_cnt_q   <= '0;
      blink_cnt_q <= '0;
      hit_q       <= 1'b0;
      vis_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      hit_q       <= hit_d;
      vis_q       <= vis_d;
    end
  end

  assign hit            = hit_q;
  assign lives          = lives_q;
  assign invuln         = (state_q == ST_INVULN);
  assign game_over      = (state_q == ST_GAME_OVER);
  assign player_visible = vis_q;
  assign state          = state_q;

endmodule

// File: tb/tb_moon_hit_ctrl.sv
module tb_moon_hit_ctrl;

  localparam int R_SUM   = 48 + 4;
  localparam int NLIVES  = 3;
  localparam int NFRAMES = 120;
  localparam int BLINK_P = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] player_x = '0, player_y = '0, moon_x = '0, moon_y = '0;
  logic       hit, invuln, player_visible, game_over;
  logic [2:0] lives;
  logic [1:0] state;

  always #5 clk = ~clk;

  moon_hit_ctrl #(
    .MOON_R(48), .PLAYER_R(4), .INIT_LIVES(NLIVES),
    .INVULN_FRAMES(NFRAMES), .BLINK_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .player_x(player_x), .player_y(player_y),
    .moon_x(moon_x), .moon_y(moon_y),
    .hit(hit), .lives(lives), .invuln(invuln),
    .player_visible(player_visible), .game_over(game_over), .state(state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: expected observable state at a given cycle.
  typedef struct {
    int cyc;
    int hit;
    int lives;
    int st;
    int vis;
  } exp_t;
  exp_t q[$];

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missed_expectation", cyc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check("hit", int'(hit), e.hit);
      check("lives", int'(lives), e.lives);
      check("state", int'(state), e.st);
      check("invuln", int'(invuln), (e.st == 2) ? 1 : 0);
      check("game_over", int'(game_over), (e.st == 3) ? 1 : 0);
      check("player_visible", int'(player_visible), e.vis);
    end else if (hit !== 1'b0) begin
      check("spurious_hit", int'(hit), 0);
    end
  end

  // Reference model: game rules at frame/event granularity.
  // m_st: 0 idle, 1 play, 2 invulnerable, 3 game over
  int m_st, m_lives, m_frames_left, m_frames_since_hit, m_vis;

  task automatic model_reset();
    m_st = 0; m_lives = NLIVES; m_frames_left = 0; m_frames_since_hit = 0; m_vis = 1;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic do_tick(input int px, input int py, input int mx, input int my);
    int t, d2, h;
    @(negedge clk);
    player_x = 10'(px); player_y = 10'(py);
    moon_x = 10'(mx);   moon_y = 10'(my);
    frame_tick = 1'b1;
    t = cyc + 1;
    if (m_st == 2) begin
      m_frames_left--;
      m_frames_since_hit++;
      m_vis = ((m_frames_since_hit / BLINK_P) % 2 == 0) ? 1 : 0;
      if (m_frames_left == 0) begin
        m_st = 1;
        m_vis = 1;
      end
    end
    d2 = (px - mx) * (px - mx) + (py - my) * (py - my);
    h = 0;
    if (m_st == 1 && d2 < R_SUM * R_SUM) begin
      h = 1;
      if (m_lives == 1) begin
        m_lives = 0; m_st = 3; m_vis = 0;
      end else begin
        m_lives--; m_st = 2; m_frames_left = NFRAMES; m_frames_since_hit = 0; m_vis = 1;
      end
    end
    q.push_back('{t + 3, h, m_lives, m_st, m_vis});
    @(negedge clk);
    frame_tick = 1'b0;
    // coordinates after the sample cycle must not matter
    player_x = 10'($urandom_range(0, 383)); player_y = 10'($urandom_range(0, 447));
    moon_x   = 10'($urandom_range(0, 383)); moon_y   = 10'($urandom_range(0, 447));
    repeat (4) @(negedge clk);
  endtask

  task automatic do_start();
    int t;
    @(negedge clk);
    start = 1'b1;
    t = cyc + 1;
    if (m_st == 0 || m_st == 3) begin
      m_st = 1; m_lives = NLIVES; m_vis = 1;
    end
    q.push_back('{t, 0, m_lives, m_st, m_vis});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_reset_values(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_lives"}, int'(lives), NLIVES);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_invuln"}, int'(invuln), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_visible"}, int'(player_visible), 1);
  endtask

  task automatic invuln_window_then_hit();
    repeat (NFRAMES - 1) do_tick(192, 140, 192, 100);
    do_tick(300, 400, 192, 100);
    do_tick(192, 140, 192, 100);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  initial begin
    #2_000_000;
    n_total++;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, my, px, py;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    do_start();                          // -> PLAY, 3 lives
    do_tick(230, 140, 192, 100);         // 3044 >= 2704: miss
    do_tick(244, 100, 192, 100);         // exactly tangent: miss
    do_tick(192, 140, 192, 100);         // 1600 < 2704: hit, lives 2, INVULN
    do_start();                          // ignored in INVULN
    invuln_window_then_hit();            // back to PLAY at frame 120, hit -> lives 1
    invuln_window_then_hit();            // last life -> GAME_OVER
    do_tick(192, 140, 192, 100);         // ignored in GAME_OVER
    do_start();                          // restart -> lives 3, PLAY
    do_start();                          // ignored in PLAY

    // Reset one cycle after a colliding tick: the hit must never appear.
    @(negedge clk);
    player_x = 10'd192; player_y = 10'd140; moon_x = 10'd192; moon_y = 10'd100;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    q.delete();
    reset = 1'b1;
    model_reset();
    #1;
    check_idle_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_reset_state", int'(state), 0);
    check("post_reset_lives", int'(lives), NLIVES);

    // Randomized play around the moon.
    do_start();
    repeat (300) begin
      mx = int'($urandom_range(0, 383));
      my = int'($urandom_range(0, 447));
      px = clampi(mx + int'($urandom_range(0, 140)) - 70, 0, 383);
      py = clampi(my + int'($urandom_range(0, 140)) - 70, 0, 447);
      if ($urandom_range(0, 7) == 0) do_start();
      do_tick(px, py, mx, my);
    end

    repeat (6) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    finish_run();
  end

endmodule
